instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  IF stage: owns the PC and drives the instr_mem read port (word address, rd_en).
//  instr_mem latches data on the negedge; this block registers {pc, instr} into the
//  IF/ID register on the next posedge for decode. Handles stall, redirect, halt, fault.
// PARAMETERS
//  RESET_PC    32'h0000_0000  byte PC loaded on reset
//  IMEM_DEPTH  1024           instr_mem words; fetch at word index >= IMEM_DEPTH faults
// PORTS
//  clk            in   1   clock; all state updates on posedge
//  rst_n          in   1   reset, synchronous, active-low
//  fetch_en_i     in   1   leave IDLE and start fetching
//  stall_i        in   1   decode back-pressure: hold PC and IF/ID
//  redirect_i     in   1   branch/jump taken: flush and load redirect_pc_i
//  redirect_pc_i  in   32  byte target; bits [1:0] forced to 0
//  halt_i         in   1   stop fetching (ebreak/ecall from decode)
//  imem_addr_o    out  32  word address to instr_mem = {2'b00, pc[31:2]}
//  imem_rd_en_o   out  1   read enable to instr_mem
//  imem_instr_i   in   32  instr_mem data (valid after the negedge of the issue cycle)
//  pc_o           out  32  current fetch PC
//  if_valid_o     out  1   IF/ID holds a real instruction
//  if_pc_o        out  32  IF/ID PC
//  if_instr_o     out  32  IF/ID instruction (NOP 32'h0000_0013 when bubble)
//  fetch_fault_o  out  1   sticky: out-of-range fetch
// BEHAVIOUR
//  Reset (rst_n=0 at posedge, also mid-operation): state=IDLE, pc=RESET_PC, if_valid=0,
//   if_pc=0, if_instr=NOP, fetch_fault=0, counters=0.
//  FSM IDLE/RUN/HALT. IDLE->RUN when fetch_en_i=1. RUN->HALT on halt_i or fault.
//   HALT exits only by reset.
//  imem_rd_en_o = (state==RUN) (combinational); 0 in IDLE/HALT. imem_addr_o always from pc.
//  Latency: pc issued in cycle n -> on if_* at posedge ending cycle n (1 cycle).
//  RUN, per posedge, priority halt > redirect > stall > fault > normal:
//   halt_i:     IF/ID<=bubble; pc held; ->HALT.
//   redirect_i: IF/ID<=bubble (wrong path); pc<={redirect_pc_i[31:2],2'b00}; stall ignored.
//   stall_i:    pc and IF/ID held; rd_en stays 1 (same-address re-read is harmless).
//   fault (pc[31:2] >= IMEM_DEPTH): fetch_fault<=1; IF/ID<=bubble; ->HALT.
//   normal:     IF/ID<={1, pc, imem_instr_i}; pc<=pc+4 (mod 2^32).
//  Fault is evaluated only on a fetch that would commit (no halt/redirect/stall).
//  IDLE/HALT: IF/ID holds bubble; pc frozen.
// CONFIGURATION
//  IFETCH_PERF_EN defined: add ports perf_fetch_cnt_o[31:0] (+1 per committed fetch)
//   and perf_redirect_cnt_o[31:0] (+1 per redirect accepted in RUN); both wrap, reset 0.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  ifetch_pkg: fetch_state_e {IDLE,RUN,HALT}, INSTR_NOP=32'h0000_0013, XLEN=32.
//  Sub-module if_id_reg: {valid,pc,instr} register with load/hold/bubble controls.
//  Top: PC register, FSM, next-PC mux, fault compare, optional counters.
// TESTING
//  Reset, fetch_en=1, mem[0..3]=A,B,C,D -> if_pc 0,4,8,C with A..D, valid=1 each cycle.
//  stall_i high 3 cycles at pc=8 -> if_* frozen on pc=4/B, pc_o=8; resumes C at release.
//  redirect_i with target 32'h0000_0043 at pc=8 -> next if_valid=0, pc_o=0x40, then mem[16].
//  stall_i and redirect_i together -> redirect wins; halt_i with redirect -> HALT, rd_en=0.
//  IMEM_DEPTH=4, straight-line run -> at pc=0x10: fetch_fault=1, bubble, HALT, rd_en=0.
//  rst_n low mid-RUN -> next posedge all outputs at reset values; IFETCH_PERF_EN counts 4/1.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ifetch_pkg;

   localparam int          XLEN      = 32;
   localparam logic [31:0] INSTR_NOP = 32'h0000_0013;   // addi x0,x0,0

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_e;

   // One IF/ID pipeline slot.
   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } if_id_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction memory read port between the fetch stage and instr_mem.
// Latency: memory returns data after the negedge of the issue cycle.
// Backpressure: none; the fetch side re-issues the same address while stalled.
//   imem_addr  word address, imem_rd_en read enable, imem_instr returned word.
interface instr_fetch_if;

   logic [ifetch_pkg::XLEN-1:0] imem_addr;
   logic                        imem_rd_en;
   logic [ifetch_pkg::XLEN-1:0] imem_instr;

   modport master (output imem_addr, output imem_rd_en, input imem_instr);
   modport slave  (input imem_addr, input imem_rd_en, output imem_instr);

endinterface

// File: rtl/instr_fetch_if_id_reg.sv
// IF/ID pipeline register holding {valid, pc, instr}.
// Latency: 1 cycle from load to output.
// Backpressure: holds its contents when neither load nor bubble is asserted.
//   clk, rst_n (sync, active-low); bubble wins over load; q is the registered slot.
module if_id_reg
   import ifetch_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic            bubble,
   input  logic [XLEN-1:0] pc_in,
   input  logic [XLEN-1:0] instr_in,
   output if_id_t          q
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q <= '{valid: 1'b0, pc: '0, instr: INSTR_NOP};
      end else if (bubble) begin
         q <= '{valid: 1'b0, pc: '0, instr: INSTR_NOP};
      end else if (load) begin
         q <= '{valid: 1'b1, pc: pc_in, instr: instr_in};
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// IF stage: owns the PC, drives the instr_mem read port, fills the IF/ID register.
// Latency: PC issued in cycle n appears on if_* after the posedge ending cycle n.
// Backpressure: stall_i holds PC and IF/ID; read enable stays high (re-read is harmless).
//   Ports: clk, rst_n (sync, active-low); fetch_en_i/stall_i/redirect_i/redirect_pc_i/halt_i
//   control; imem (instr_fetch_if.master) memory port; pc_o, if_valid_o, if_pc_o, if_instr_o,
//   fetch_fault_o (sticky). Define IFETCH_PERF_EN to add perf_fetch_cnt_o/perf_redirect_cnt_o.
module instr_fetch
   import ifetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          IMEM_DEPTH = 1024
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fetch_en_i,
   input  logic              stall_i,
   input  logic              redirect_i,
   input  logic [XLEN-1:0]   redirect_pc_i,
   input  logic              halt_i,
   instr_fetch_if.master     imem,
   output logic [XLEN-1:0]   pc_o,
   output logic              if_valid_o,
   output logic [XLEN-1:0]   if_pc_o,
   output logic [XLEN-1:0]   if_instr_o,
`ifdef IFETCH_PERF_EN
   output logic [31:0]       perf_fetch_cnt_o,
   output logic [31:0]       perf_redirect_cnt_o,
`endif
   output logic              fetch_fault_o
);

   localparam logic [31:0] DEPTH_W = 32'(IMEM_DEPTH);

   fetch_state_e    state;
   logic [XLEN-1:0] pc;
   logic            fault;
   logic [31:0]     word_idx;
   logic            run;
   logic            fault_hit;
   logic            commit;
   logic            bubble;
   if_id_t          if_id;

`ifdef IFETCH_PERF_EN
   logic [31:0]     fetch_cnt;
   logic [31:0]     redirect_cnt;
`endif

   assign word_idx  = {2'b00, pc[31:2]};
   assign run       = (state == RUN);
   assign fault_hit = (word_idx >= DEPTH_W);

   // Priority halt > redirect > stall > fault > normal. A fault is only
   // raised by a fetch that would otherwise commit.
   assign commit = run & ~halt_i & ~redirect_i & ~stall_i & ~fault_hit;
   assign bubble = ~run | halt_i | redirect_i | (~stall_i & fault_hit);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         pc    <= RESET_PC;
         fault <= 1'b0;
`ifdef IFETCH_PERF_EN
         fetch_cnt    <= '0;
         redirect_cnt <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (fetch_en_i) state <= RUN;
            end
            RUN: begin
               if (halt_i) begin
                  state <= HALT;
               end else if (redirect_i) begin
                  pc <= redirect_pc_i & ~32'd3;
`ifdef IFETCH_PERF_EN
                  redirect_cnt <= redirect_cnt + 32'd1;
`endif
               end else if (stall_i) begin
                  pc <= pc;
               end else if (fault_hit) begin
                  fault <= 1'b1;
                  state <= HALT;
               end else begin
                  pc <= pc + 32'd4;
`ifdef IFETCH_PERF_EN
                  fetch_cnt <= fetch_cnt + 32'd1;
`endif
               end
            end
            default: begin
               // HALT is left only through reset.
               state <= HALT;
            end
         endcase
      end
   end

   if_id_reg u_if_id (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (commit),
      .bubble   (bubble),
      .pc_in    (pc),
      .instr_in (imem.imem_instr),
      .q        (if_id)
   );

   assign imem.imem_addr  = word_idx;
   assign imem.imem_rd_en = run;

   assign pc_o          = pc;
   assign if_valid_o    = if_id.valid;
   assign if_pc_o       = if_id.pc;
   assign if_instr_o    = if_id.instr;
   assign fetch_fault_o = fault;

`ifdef IFETCH_PERF_EN
   assign perf_fetch_cnt_o    = fetch_cnt;
   assign perf_redirect_cnt_o = redirect_cnt;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a full-depth instance and an IMEM_DEPTH=4 instance
// share stimulus; expected rows are queued when driven and compared one cycle later.
// Each instance has a negedge-latching instruction memory model.
module tb_instr_fetch;
   import ifetch_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        fetch_en, stall, redirect, halt;
   logic [31:0] redirect_pc;

   logic [31:0] pc, if_pc, if_instr;
   logic        if_valid, fault;
   logic [31:0] pc_f, if_pc_f, if_instr_f;
   logic        if_valid_f, fault_f;
`ifdef IFETCH_PERF_EN
   logic [31:0] perf_fetch, perf_redir, perf_fetch_f, perf_redir_f;
`endif

   instr_fetch_if bus ();
   instr_fetch_if bus_f ();

   always #5 clk = ~clk;

   instr_fetch #(.RESET_PC(32'h0), .IMEM_DEPTH(1024)) dut (
      .clk(clk), .rst_n(rst_n), .fetch_en_i(fetch_en), .stall_i(stall),
      .redirect_i(redirect), .redirect_pc_i(redirect_pc), .halt_i(halt),
      .imem(bus.master), .pc_o(pc), .if_valid_o(if_valid), .if_pc_o(if_pc),
      .if_instr_o(if_instr),
`ifdef IFETCH_PERF_EN
      .perf_fetch_cnt_o(perf_fetch), .perf_redirect_cnt_o(perf_redir),
`endif
      .fetch_fault_o(fault)
   );

   instr_fetch #(.RESET_PC(32'h0), .IMEM_DEPTH(4)) dut_f (
      .clk(clk), .rst_n(rst_n), .fetch_en_i(fetch_en), .stall_i(stall),
      .redirect_i(redirect), .redirect_pc_i(redirect_pc), .halt_i(halt),
      .imem(bus_f.master), .pc_o(pc_f), .if_valid_o(if_valid_f), .if_pc_o(if_pc_f),
      .if_instr_o(if_instr_f),
`ifdef IFETCH_PERF_EN
      .perf_fetch_cnt_o(perf_fetch_f), .perf_redirect_cnt_o(perf_redir_f),
`endif
      .fetch_fault_o(fault_f)
   );

   logic [31:0] mem [0:63];

   always @(negedge clk) begin
      if (bus.imem_rd_en === 1'b1)   bus.imem_instr   <= mem[bus.imem_addr[5:0]];
      if (bus_f.imem_rd_en === 1'b1) bus_f.imem_instr <= mem[bus_f.imem_addr[5:0]];
   end

   typedef struct {
      logic        rst_n, fe, st, rd;
      logic [31:0] rpc;
      logic        ht;
      logic        ev, ckpc;
      logic [31:0] eifpc, einstr, epc;
      logic        erd;
      logic        ckf, ef_flt, ef_v;
      logic [31:0] ef_pc;
      logic        ef_rd;
      logic        ckp;
      logic [31:0] ep_f, ep_r;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   row   = 0;

   task automatic add(input logic r, input logic fe, input logic st, input logic rd,
                      input logic [31:0] rpc, input logic ht, input logic ev,
                      input logic ckpc, input logic [31:0] eifpc, input logic [31:0] einstr,
                      input logic [31:0] epc, input logic erd);
      vec_t v;
      v.rst_n = r; v.fe = fe; v.st = st; v.rd = rd; v.rpc = rpc; v.ht = ht;
      v.ev = ev; v.ckpc = ckpc; v.eifpc = eifpc; v.einstr = einstr; v.epc = epc; v.erd = erd;
      v.ckf = 1'b0; v.ef_flt = 1'b0; v.ef_v = 1'b0; v.ef_pc = '0; v.ef_rd = 1'b0;
      v.ckp = 1'b0; v.ep_f = '0; v.ep_r = '0;
      tbl.push_back(v);
   endtask

   task automatic setf(input logic flt, input logic v, input logic [31:0] p, input logic r);
      int k = tbl.size() - 1;
      tbl[k].ckf = 1'b1; tbl[k].ef_flt = flt; tbl[k].ef_v = v; tbl[k].ef_pc = p; tbl[k].ef_rd = r;
   endtask

   task automatic setp(input logic [31:0] f, input logic [31:0] r);
      int k = tbl.size() - 1;
      tbl[k].ckp = 1'b1; tbl[k].ep_f = f; tbl[k].ep_r = r;
   endtask

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s (row %0d): got %h, expected %h", nm, row, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t e;
      int   n;
      for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 + 32'(i) * 32'h0000_0101;
      rst_n = 1'b0; fetch_en = 1'b0; stall = 1'b0; redirect = 1'b0; halt = 1'b0;
      redirect_pc = '0;

      // Block A: straight-line run; depth-4 instance faults at pc 0x10.
      add(0,0,0,0,0,0, 0,1,32'h0,INSTR_NOP,32'h0,0);  setf(0,0,32'h0,0); setp(0,0);
      add(0,0,0,0,0,0, 0,1,32'h0,INSTR_NOP,32'h0,0);  setf(0,0,32'h0,0);
      add(1,1,0,0,0,0, 0,0,32'h0,INSTR_NOP,32'h0,1);  setf(0,0,32'h0,1);
      add(1,1,0,0,0,0, 1,1,32'h0,mem[0],32'h4,1);     setf(0,1,32'h4,1);
      add(1,1,0,0,0,0, 1,1,32'h4,mem[1],32'h8,1);     setf(0,1,32'h8,1);
      add(1,1,0,0,0,0, 1,1,32'h8,mem[2],32'hC,1);     setf(0,1,32'hC,1);
      add(1,1,0,0,0,0, 1,1,32'hC,mem[3],32'h10,1);    setf(0,1,32'h10,1);
      add(1,1,0,0,0,0, 1,1,32'h10,mem[4],32'h14,1);   setf(1,0,32'h10,0);
      add(1,1,0,0,0,0, 1,1,32'h14,mem[5],32'h18,1);   setf(1,0,32'h10,0);
      // Block B: stall, redirect, stall+redirect, halt+redirect.
      add(0,1,0,0,0,0, 0,1,32'h0,INSTR_NOP,32'h0,0);  setf(0,0,32'h0,0);
      add(1,1,0,0,0,0, 0,0,32'h0,INSTR_NOP,32'h0,1);
      add(1,1,0,0,0,0, 1,1,32'h0,mem[0],32'h4,1);
      add(1,1,0,0,0,0, 1,1,32'h4,mem[1],32'h8,1);
      for (int i = 0; i < 3; i++) add(1,1,1,0,0,0, 1,1,32'h4,mem[1],32'h8,1);
      add(1,1,0,0,0,0, 1,1,32'h8,mem[2],32'hC,1);
      add(1,1,0,1,32'h43,0, 0,0,32'h0,INSTR_NOP,32'h40,1);
      add(1,1,0,0,0,0, 1,1,32'h40,mem[16],32'h44,1);
      add(1,1,1,1,32'h21,0, 0,0,32'h0,INSTR_NOP,32'h20,1);
      add(1,1,0,0,0,0, 1,1,32'h20,mem[8],32'h24,1);
      add(1,1,0,1,32'h30,1, 0,0,32'h0,INSTR_NOP,32'h24,0);
      add(1,1,0,1,32'h50,0, 0,0,32'h0,INSTR_NOP,32'h24,0);
      // Block C: four commits, one redirect, then reset mid-RUN.
      add(0,1,0,0,0,0, 0,1,32'h0,INSTR_NOP,32'h0,0);
      add(1,1,0,0,0,0, 0,0,32'h0,INSTR_NOP,32'h0,1);
      add(1,1,0,0,0,0, 1,1,32'h0,mem[0],32'h4,1);
      add(1,1,0,0,0,0, 1,1,32'h4,mem[1],32'h8,1);
      add(1,1,0,0,0,0, 1,1,32'h8,mem[2],32'hC,1);
      add(1,1,0,0,0,0, 1,1,32'hC,mem[3],32'h10,1);
      add(1,1,0,1,32'h4,0, 0,0,32'h0,INSTR_NOP,32'h4,1); setp(4,1);
      add(0,1,0,0,0,0, 0,1,32'h0,INSTR_NOP,32'h0,0);  setf(0,0,32'h0,0); setp(0,0);

      for (int i = 0; i < tbl.size(); i++) begin
         row = i;
         rst_n = tbl[i].rst_n; fetch_en = tbl[i].fe; stall = tbl[i].st;
         redirect = tbl[i].rd; redirect_pc = tbl[i].rpc; halt = tbl[i].ht;
         sb.push_back(tbl[i]);
         step();
         e = sb.pop_front();
         cmp("if_valid", {31'd0, if_valid}, {31'd0, e.ev});
         cmp("if_instr", if_instr, e.einstr);
         cmp("pc_o", pc, e.epc);
         cmp("imem_rd_en", {31'd0, bus.imem_rd_en}, {31'd0, e.erd});
         cmp("imem_addr", bus.imem_addr, {2'b00, e.epc[31:2]});
         cmp("fetch_fault", {31'd0, fault}, 32'd0);
         if (e.ckpc) cmp("if_pc", if_pc, e.eifpc);
         if (e.ckf) begin
            cmp("f_fetch_fault", {31'd0, fault_f}, {31'd0, e.ef_flt});
            cmp("f_if_valid", {31'd0, if_valid_f}, {31'd0, e.ef_v});
            cmp("f_pc_o", pc_f, e.ef_pc);
            cmp("f_imem_rd_en", {31'd0, bus_f.imem_rd_en}, {31'd0, e.ef_rd});
         end
`ifdef IFETCH_PERF_EN
         if (e.ckp) begin
            cmp("perf_fetch_cnt", perf_fetch, e.ep_f);
            cmp("perf_redirect_cnt", perf_redir, e.ep_r);
         end
`endif
      end

      // Hand sequence: first instruction lands exactly two cycles after fetch_en.
      row = -1;
      rst_n = 1'b0; fetch_en = 1'b0; stall = 1'b0; redirect = 1'b0; halt = 1'b0;
      step();
      rst_n = 1'b1; fetch_en = 1'b1;
      n = 0;
      while (if_valid !== 1'b1 && n < 10) begin
         step();
         n++;
      end
      cmp("first_valid_timeout", {31'd0, if_valid}, 32'd1);
      cmp("first_fetch_latency", 32'(n), 32'd2);
      cmp("first_if_pc", if_pc, 32'h0);
      cmp("first_if_instr", if_instr, mem[0]);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
